// File: rtl/tetris_line_clear_engine.sv
// tetris_line_clear_engine
// Bottom-up scan of the scene memory: full rows are dropped, the remaining rows are
// compacted toward the bottom, and the rows freed at the top are zero-filled.
// The engine has no storage of its own. It drives a single-port memory with a
// 1-cycle read latency.
// Optional macro TETRIS_LINE_CLEAR_SCORE_EN adds the score_o accumulator.
//
// state   | meaning
// --------+----------------------------------------------------------
// S_IDLE  | ready for start; registers hold last result
// S_READ  | read strobe for row r_rd
// S_CHECK | row data valid; drop if full, else copy to r_wr if moved
// S_FILL  | zero rows r_wr down to 0 (r_wr reused as fill pointer)
// S_DONE  | one-cycle completion pulse, publish count (and score)
module tetris_line_clear_engine #(
   parameter  int width_p   = 16,
   parameter  int height_p  = 32,
   localparam int addr_w_lp = $clog2(height_p),
   localparam int cnt_w_lp  = $clog2(height_p + 1)
) (
   input  logic                  clk_i,
   input  logic                  reset_i,
   input  logic                  start_v_i,
   output logic                  ready_o,
   output logic [addr_w_lp-1:0]  row_addr_o,
   output logic                  row_re_o,
   input  logic [width_p-1:0]    row_rdata_i,
   output logic                  row_we_o,
   output logic [width_p-1:0]    row_wdata_o,
   output logic                  done_v_o,
   output logic [cnt_w_lp-1:0]   lines_cleared_o
`ifdef TETRIS_LINE_CLEAR_SCORE_EN
   ,output logic [31:0]          score_o
`endif
);

   typedef enum logic [2:0] {S_IDLE, S_READ, S_CHECK, S_FILL, S_DONE} state_t;

   localparam logic [addr_w_lp-1:0] c_bottom = addr_w_lp'(height_p - 1);

   state_t                r_state, w_state_nxt;
   logic [addr_w_lp-1:0]  r_rd, w_rd_nxt;
   logic [addr_w_lp-1:0]  r_wr, w_wr_nxt;
   logic [cnt_w_lp-1:0]   r_cnt, w_cnt_nxt;
   logic [cnt_w_lp-1:0]   r_lines, w_lines_nxt;
   logic                  w_full;
   logic [cnt_w_lp-1:0]   w_cnt_inc;

   assign w_full          = &row_rdata_i;
   assign w_cnt_inc       = r_cnt + cnt_w_lp'(w_full);
   assign lines_cleared_o = r_lines;

`ifdef TETRIS_LINE_CLEAR_SCORE_EN
   logic [31:0] r_score, w_score_nxt;
   logic [3:0]  w_pts;
   logic [32:0] w_sum;

   // Points for the current clear count, then saturating accumulate
   always_comb begin
      w_pts = 4'd0;
      if (r_cnt >= cnt_w_lp'(4))      w_pts = 4'd8;
      else if (r_cnt == cnt_w_lp'(3)) w_pts = 4'd5;
      else if (r_cnt == cnt_w_lp'(2)) w_pts = 4'd3;
      else if (r_cnt == cnt_w_lp'(1)) w_pts = 4'd1;
      w_sum       = {1'b0, r_score} + 33'(w_pts);
      w_score_nxt = r_score;
      if (r_state == S_DONE) w_score_nxt = w_sum[32] ? 32'hFFFF_FFFF : w_sum[31:0];
   end

   // Score register, cleared only by reset
   always_ff @(posedge clk_i) begin
      if (reset_i) r_score <= '0;
      else         r_score <= w_score_nxt;
   end

   assign score_o = r_score;
`endif

   // State and datapath registers
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         r_state <= S_IDLE;
         r_rd    <= '0;
         r_wr    <= '0;
         r_cnt   <= '0;
         r_lines <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_rd    <= w_rd_nxt;
         r_wr    <= w_wr_nxt;
         r_cnt   <= w_cnt_nxt;
         r_lines <= w_lines_nxt;
      end
   end

   // Next-state, datapath update and memory strobes
   always_comb begin
      w_state_nxt = r_state;
      w_rd_nxt    = r_rd;
      w_wr_nxt    = r_wr;
      w_cnt_nxt   = r_cnt;
      w_lines_nxt = r_lines;
      ready_o     = 1'b0;
      row_re_o    = 1'b0;
      row_we_o    = 1'b0;
      row_addr_o  = '0;
      row_wdata_o = '0;
      done_v_o    = 1'b0;
      unique case (r_state)
         S_IDLE: begin
            ready_o = 1'b1;
            if (start_v_i) begin
               w_rd_nxt    = c_bottom;
               w_wr_nxt    = c_bottom;
               w_cnt_nxt   = '0;
               w_state_nxt = S_READ;
            end
         end
         S_READ: begin
            row_re_o    = 1'b1;
            row_addr_o  = r_rd;
            w_state_nxt = S_CHECK;
         end
         S_CHECK: begin
            w_cnt_nxt = w_cnt_inc;
            if (!w_full) begin
               w_wr_nxt = r_wr - addr_w_lp'(1);
               if (r_rd != r_wr) begin
                  row_we_o    = 1'b1;
                  row_addr_o  = r_wr;
                  row_wdata_o = row_rdata_i;
               end
            end
            if (r_rd == '0) begin
               // Last row scanned: r_wr becomes the top-down fill pointer
               w_wr_nxt    = addr_w_lp'(w_cnt_inc - cnt_w_lp'(1));
               w_state_nxt = (w_cnt_inc == '0) ? S_DONE : S_FILL;
            end else begin
               w_rd_nxt    = r_rd - addr_w_lp'(1);
               w_state_nxt = S_READ;
            end
         end
         S_FILL: begin
            row_we_o   = 1'b1;
            row_addr_o = r_wr;
            if (r_wr == '0) w_state_nxt = S_DONE;
            else            w_wr_nxt    = r_wr - addr_w_lp'(1);
         end
         S_DONE: begin
            done_v_o    = 1'b1;
            w_lines_nxt = r_cnt;
            w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

endmodule

// File: tb/tb_tetris_line_clear_engine.sv
// Bench for tetris_line_clear_engine (16x32). Holds a behavioural scene memory.
// An independent compaction model computes, for each op, the final board, the
// clear count, the write count and the latency. These go through a scoreboard
// queue. Define TETRIS_LINE_CLEAR_SCORE_EN to also check score_o.
module tb_tetris_line_clear_engine;

   localparam int W = 16;
   localparam int H = 32;

   typedef struct {
      int          lines;
      int          lat;
      int          wr;
      logic [31:0] score;
   } exp_t;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          start = 1'b0;
   logic          ready;
   logic [4:0]    addr;
   logic          re;
   logic [W-1:0]  rdata;
   logic          we;
   logic [W-1:0]  wdata;
   logic          done;
   logic [5:0]    lines;
`ifdef TETRIS_LINE_CLEAR_SCORE_EN
   logic [31:0]   score;
`endif

   logic [W-1:0]  mem    [H];
   logic [W-1:0]  ld_img [H];
   logic          ld_en = 1'b0;
   logic [W-1:0]  brd    [H];
   logic [W-1:0]  exp_img[H];
   exp_t          sb[$];
   logic [31:0]   exp_score = '0;
   int            n_wr = 0;
   int            n_ovl = 0;
   int            n_chk = 0;
   int            n_bad = 0;

   tetris_line_clear_engine #(.width_p(W), .height_p(H)) dut (
      .clk_i           (clk),
      .reset_i         (reset),
      .start_v_i       (start),
      .ready_o         (ready),
      .row_addr_o      (addr),
      .row_re_o        (re),
      .row_rdata_i     (rdata),
      .row_we_o        (we),
      .row_wdata_o     (wdata),
      .done_v_o        (done),
      .lines_cleared_o (lines)
`ifdef TETRIS_LINE_CLEAR_SCORE_EN
      ,.score_o        (score)
`endif
   );

   always #5 clk = ~clk;

   // Scene memory: 1-cycle read latency, bench preload port
   always @(posedge clk) begin
      if (re) rdata <= mem[addr];
      if (we) mem[addr] <= wdata;
      if (ld_en) mem <= ld_img;
      if (we) n_wr <= n_wr + 1;
      if (re && we) n_ovl <= n_ovl + 1;
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // Reference: keep non-full rows in bottom-up order, stack them from the bottom
   task automatic model_push();
      exp_t e;
      int   k = H - 1;
      int   cnt = 0;
      int   wr = 0;
      int   pts;
      for (int r = 0; r < H; r++) exp_img[r] = '0;
      for (int r = H - 1; r >= 0; r--) begin
         if (brd[r] == {W{1'b1}}) cnt++;
         else begin
            exp_img[k] = brd[r];
            if (k != r) wr++;
            k--;
         end
      end
      pts = (cnt == 0) ? 0 : (cnt == 1) ? 1 : (cnt == 2) ? 3 : (cnt == 3) ? 5 : 8;
      exp_score = exp_score + 32'(pts);
      e.lines = cnt;
      e.lat   = 2 * H + cnt + 1;
      e.wr    = wr + cnt;
      e.score = exp_score;
      sb.push_back(e);
   endtask

   task automatic load_board();
      ld_img = brd;
      @(negedge clk);
      ld_en = 1'b1;
      @(posedge clk);
      #1 ld_en = 1'b0;
   endtask

   task automatic run_op(input string name, input bit pulse_mid);
      exp_t e;
      int   got_lat = 0;
      load_board();
      model_push();
      @(negedge clk);
      chk({name, "_ready"}, 64'(ready), 64'd1);
      n_wr = 0;
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      for (int c = 1; c <= 200; c++) begin
         @(negedge clk);
         if (done) begin
            got_lat = c;
            break;
         end
         if (pulse_mid && c == 10) begin
            start = 1'b1;
            @(posedge clk);
            #1 start = 1'b0;
         end
      end
      chk({name, "_latency"}, 64'(got_lat), 64'(sb[0].lat));
      // Start offered in the DONE cycle must be ignored
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      @(negedge clk);
      e = sb.pop_front();
      chk({name, "_ready_after"}, 64'(ready), 64'd1);
      chk({name, "_done_pulse"}, 64'(done), 64'd0);
      chk({name, "_lines"}, 64'(lines), 64'(e.lines));
      chk({name, "_writes"}, 64'(n_wr), 64'(e.wr));
`ifdef TETRIS_LINE_CLEAR_SCORE_EN
      chk({name, "_score"}, 64'(score), 64'(e.score));
`endif
      for (int r = 0; r < H; r++)
         chk($sformatf("%s_row%0d", name, r), 64'(mem[r]), 64'(exp_img[r]));
   endtask

   initial begin
      for (int r = 0; r < H; r++) brd[r] = '0;
      repeat (3) @(posedge clk);
      #1;
      @(negedge clk);
      chk("rst_ready", 64'(ready), 64'd1);
      chk("rst_re", 64'(re), 64'd0);
      chk("rst_we", 64'(we), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      chk("rst_addr", 64'(addr), 64'd0);
      chk("rst_wdata", 64'(wdata), 64'd0);
      chk("rst_lines", 64'(lines), 64'd0);
`ifdef TETRIS_LINE_CLEAR_SCORE_EN
      chk("rst_score", 64'(score), 64'd0);
`endif
      reset = 1'b0;

      run_op("empty", 1'b0);

      for (int r = 0; r < H; r++) brd[r] = '0;
      brd[31] = 16'hFFFF;
      run_op("bottom_full", 1'b0);

      for (int r = 0; r < 28; r++) brd[r] = 16'(r * 257 + 3);
      brd[28] = 16'hFFFF;
      brd[29] = 16'h00F0;
      brd[30] = 16'hFFFF;
      brd[31] = 16'h0001;
      run_op("two_gaps", 1'b0);

      for (int r = 0; r < H; r++) brd[r] = 16'hFFFF;
      run_op("all_full", 1'b0);

      // Reset during FILL of an all-full board
      for (int r = 0; r < H; r++) brd[r] = 16'hFFFF;
      load_board();
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (70) @(posedge clk);
      #1 reset = 1'b1;
      @(posedge clk);
      #1;
      @(negedge clk);
      chk("midrst_ready", 64'(ready), 64'd1);
      chk("midrst_done", 64'(done), 64'd0);
      chk("midrst_lines", 64'(lines), 64'd0);
      exp_score = '0;
`ifdef TETRIS_LINE_CLEAR_SCORE_EN
      chk("midrst_score", 64'(score), 64'd0);
`endif
      reset = 1'b0;

      for (int r = 0; r < H; r++) brd[r] = 16'($urandom) & 16'h7FFF;
      brd[20] = 16'hFFFF;
      run_op("pulse_one", 1'b1);

      for (int r = 0; r < H; r++) brd[r] = 16'($urandom) & 16'hFEFF;
      brd[0]  = 16'hFFFF;
      brd[5]  = 16'hFFFF;
      brd[6]  = 16'hFFFF;
      brd[31] = 16'hFFFF;
      run_op("four", 1'b0);

      for (int r = 0; r < H; r++)
         brd[r] = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom) & 16'hFFF7;
      run_op("random", 1'b0);

      chk("re_we_overlap", 64'(n_ovl), 64'd0);
      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
